// File: rtl/mac_t_frame_buf.sv
// Transmit frame buffer ahead of the GMII MAC: stores whole frames in a circular
// byte buffer and releases them to the read side only once committed with a length descriptor.
module mac_t_frame_buf #(
  parameter int DATA_AW = 12,
  parameter int PTR_AW  = 5,
  parameter int MAX_LEN = 1514
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  input  logic        data_fifo_rd,
  output logic [7:0]  data_fifo_dout,
  input  logic        ptr_fifo_rd,
  output logic [15:0] ptr_fifo_dout,
  output logic        ptr_fifo_empty,
  output logic [15:0] drop_cnt
);

  localparam int DEPTH  = 1 << DATA_AW;
  localparam int PDEPTH = 1 << PTR_AW;
  localparam logic [DATA_AW:0] D_ONE   = 1;
  localparam logic [DATA_AW:0] D_DEPTH = DEPTH[DATA_AW:0];
  localparam logic [PTR_AW:0]  P_ONE   = 1;
  localparam logic [PTR_AW:0]  P_DEPTH = PDEPTH[PTR_AW:0];
  localparam logic [10:0]      L_MAX   = MAX_LEN[10:0];

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic [7:0]  data_mem [DEPTH];
  logic [10:0] ptr_mem  [PDEPTH];

  logic [0:0]       state_reg, state_next;
  logic [DATA_AW:0] wr_ptr_reg, wr_ptr_next;
  logic [DATA_AW:0] rd_ptr_reg;
  logic [DATA_AW:0] commit_ptr_reg, commit_ptr_next;
  logic [PTR_AW:0]  pwr_ptr_reg, prd_ptr_reg;
  logic [10:0]      len_reg, len_next;
  logic             drop_reg, drop_next;
  logic [15:0]      drop_cnt_reg;
  logic [7:0]       dout_reg;
  logic [15:0]      pdout_reg;

  logic                 data_full, ptr_full, accept;
  logic                 mem_we, push;
  logic [DATA_AW-1:0]   mem_waddr;
  logic [1:0]           drop_inc;
  logic                 data_rd_ok, ptr_rd_ok;
  logic [16:0]          drop_sum;

  assign data_full      = (wr_ptr_reg - rd_ptr_reg) == D_DEPTH;
  assign ptr_full       = (pwr_ptr_reg - prd_ptr_reg) == P_DEPTH;
  assign in_ready       = !data_full && !ptr_full;
  assign accept         = in_valid && in_ready;
  assign ptr_fifo_empty = (pwr_ptr_reg == prd_ptr_reg);
  assign data_rd_ok     = data_fifo_rd && (rd_ptr_reg != commit_ptr_reg);
  assign ptr_rd_ok      = ptr_fifo_rd && !ptr_fifo_empty;
  assign drop_sum       = {1'b0, drop_cnt_reg} + {15'd0, drop_inc};

  assign data_fifo_dout = dout_reg;
  assign ptr_fifo_dout  = pdout_reg;
  assign drop_cnt       = drop_cnt_reg;

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    len_next        = len_reg;
    drop_next       = drop_reg;
    mem_we          = 1'b0;
    mem_waddr       = wr_ptr_reg[DATA_AW-1:0];
    push            = 1'b0;
    drop_inc        = 2'd0;
    if (accept) begin
      if (in_sof) begin
        // A sof always restarts at the last commit point, which also rewinds an open frame.
        if (state_reg == ST_FRAME) drop_inc = 2'd1;
        mem_we      = 1'b1;
        mem_waddr   = commit_ptr_reg[DATA_AW-1:0];
        wr_ptr_next = commit_ptr_reg + D_ONE;
        len_next    = 11'd1;
        drop_next   = 1'b0;
        state_next  = ST_FRAME;
      end else if (state_reg == ST_FRAME) begin
        if (drop_reg || len_reg >= L_MAX) begin
          drop_next = 1'b1;
        end else begin
          mem_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + D_ONE;
          len_next    = len_reg + 11'd1;
        end
      end
      if (in_eof && (in_sof || state_reg == ST_FRAME)) begin
        state_next = ST_IDLE;
        if (!drop_next && !in_err) begin
          push            = 1'b1;
          commit_ptr_next = wr_ptr_next;
        end else begin
          wr_ptr_next = commit_ptr_reg;
          drop_inc    = drop_inc + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      pwr_ptr_reg    <= '0;
      prd_ptr_reg    <= '0;
      len_reg        <= '0;
      drop_reg       <= 1'b0;
      drop_cnt_reg   <= '0;
      dout_reg       <= '0;
      pdout_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      len_reg        <= len_next;
      drop_reg       <= drop_next;
      drop_cnt_reg   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (push) pwr_ptr_reg <= pwr_ptr_reg + P_ONE;
      if (data_rd_ok) begin
        dout_reg   <= data_mem[rd_ptr_reg[DATA_AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + D_ONE;
      end
      if (ptr_rd_ok) begin
        pdout_reg   <= {5'd0, ptr_mem[prd_ptr_reg[PTR_AW-1:0]]};
        prd_ptr_reg <= prd_ptr_reg + P_ONE;
      end
    end
  end

  // Storage arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_waddr] <= in_data;
    if (push)   ptr_mem[pwr_ptr_reg[PTR_AW-1:0]] <= len_next;
  end

endmodule

// File: tb/tb_mac_t_frame_buf.sv
// Self-checking bench for mac_t_frame_buf: table vectors, directed corner sequences
// and random frames checked against a frame-level queue model.
module tb_mac_t_frame_buf;
  localparam int MAX_LEN = 1514;
  localparam int BUF_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        in_err = 1'b0;
  logic        data_fifo_rd = 1'b0;
  logic [7:0]  data_fifo_dout;
  logic        ptr_fifo_rd = 1'b0;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_empty;
  logic [15:0] drop_cnt;

  mac_t_frame_buf #(.DATA_AW(12), .PTR_AW(5), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout),
    .ptr_fifo_empty(ptr_fifo_empty), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Frame-level reference: committed lengths, committed payload bytes, discard count.
  int          exp_desc[$];
  byte unsigned exp_bytes[$];
  int          model_drop = 0;

  typedef struct {
    int len;
    bit err;
    int abort_at;
    int seed;
    bit exp_commit;
    int exp_desc;
    int exp_drop_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input logic r);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e; in_err = r;
    while (!in_ready && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1 within 5000 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "input stalled");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
  endtask

  task automatic model_commit(input int len, input int seed, input int start, input bit err);
    if (len <= MAX_LEN && !err) begin
      exp_desc.push_back(len);
      for (int i = 0; i < len; i++) exp_bytes.push_back(8'(seed + start + i));
    end else begin
      model_drop++;
    end
  endtask

  task automatic send_frame(input int len, input bit err, input int abort_at, input int seed);
    for (int i = 0; i < len; i++)
      send_beat(8'(seed + i), (i == 0) || (abort_at > 0 && i == abort_at), i == len - 1,
                (i == len - 1) ? err : 1'b0);
    if (abort_at > 0) begin
      model_drop++;
      model_commit(len - abort_at, seed, abort_at, err);
    end else begin
      model_commit(len, seed, 0, err);
    end
    $display("frame len=%0d err=%0d abort_at=%0d seed=%0d", len, err, abort_at, seed);
  endtask

  task automatic read_desc(output logic [15:0] v);
    ptr_fifo_rd = 1'b1;
    @(posedge clk); #1;
    ptr_fifo_rd = 1'b0;
    v = ptr_fifo_dout;
  endtask

  task automatic read_bytes(input int n);
    data_fifo_rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("data_byte", data_fifo_dout, exp_bytes.pop_front());
    end
    data_fifo_rd = 1'b0;
  endtask

  task automatic drain_all();
    logic [15:0] v;
    int nd;
    nd = exp_desc.size();
    while (exp_desc.size() > 0) begin
      read_desc(v);
      chk("desc", v, exp_desc.pop_front());
    end
    read_bytes(exp_bytes.size());
    chk("empty_after_drain", ptr_fifo_empty, 1);
    $display("drain descriptors=%0d", nd);
  endtask

  initial begin
    logic [15:0] v;
    int tbl_drop;
    int len, abort_at, room;
    bit err;

    vecs[0] = '{64,   0, 0,  0,    1, 16'h0040, 0};
    vecs[1] = '{1515, 0, 0,  8'h11, 0, 0,        1};
    vecs[2] = '{60,   0, 0,  8'h20, 1, 16'h003C, 0};
    vecs[3] = '{100,  1, 0,  8'h30, 0, 0,        1};
    vecs[4] = '{50,   0, 29, 8'h40, 1, 16'h0015, 1};
    vecs[5] = '{1,    0, 0,  8'h55, 1, 16'h0001, 0};
    vecs[6] = '{1514, 0, 0,  8'h60, 1, 16'h05EA, 0};
    vecs[7] = '{1,    1, 0,  8'h70, 0, 0,        1};

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data_dout", data_fifo_dout, 0);
    chk("rst_ptr_dout", ptr_fifo_dout, 0);
    chk("rst_empty", ptr_fifo_empty, 1);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames
    tbl_drop = 0;
    for (int k = 0; k < 8; k++) begin
      send_frame(vecs[k].len, vecs[k].err, vecs[k].abort_at, vecs[k].seed);
      tbl_drop += vecs[k].exp_drop_inc;
      chk("tbl_drop_cnt", drop_cnt, tbl_drop);
      chk("tbl_empty", ptr_fifo_empty, !vecs[k].exp_commit);
      if (vecs[k].exp_commit) begin
        read_desc(v);
        chk("tbl_desc", v, vecs[k].exp_desc);
        void'(exp_desc.pop_front());
        read_bytes(exp_bytes.size());
        chk("tbl_empty_after", ptr_fifo_empty, 1);
      end
    end

    // Reads on empty hold their outputs
    v = ptr_fifo_dout;
    read_desc(v);
    chk("ptr_empty_hold", v, 16'h05EA);
    data_fifo_rd = 1'b1;
    @(posedge clk); #1;
    data_fifo_rd = 1'b0;
    chk("data_empty_hold", data_fifo_dout, 8'(8'h60 + 1513));

    // Descriptor FIFO full: 32 short frames, then one pop re-opens input
    for (int f = 0; f < 32; f++) send_frame(10, 0, 0, f * 16);
    chk("ptr_full_ready", in_ready, 0);
    read_desc(v);
    chk("ptr_full_desc", v, exp_desc.pop_front());
    chk("ptr_pop_ready", in_ready, 1);
    send_frame(10, 0, 0, 8'h77);
    chk("frame33_empty", ptr_fifo_empty, 0);
    drain_all();

    // Data buffer full in the middle of the third max-size frame
    send_frame(1514, 0, 0, 1);
    send_frame(1514, 0, 0, 2);
    for (int i = 0; i < 1068; i++) send_beat(8'(3 + i), i == 0, 1'b0, 1'b0);
    chk("data_full_ready", in_ready, 0);
    read_desc(v);
    chk("full_desc1", v, exp_desc.pop_front());
    read_bytes(1);
    chk("data_free_ready", in_ready, 1);
    read_bytes(1513);
    for (int i = 1068; i < 1514; i++) send_beat(8'(3 + i), 1'b0, i == 1513, 1'b0);
    model_commit(1514, 3, 0, 0);
    chk("frame3_desc_model", exp_desc[exp_desc.size()-1], 16'h05EA);
    drain_all();

    // Random frames against the queue model
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, 1600);
      err = ($urandom_range(0, 7) == 0);
      abort_at = (len > 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : 0;
      room = (len < MAX_LEN) ? len : MAX_LEN;
      if (exp_bytes.size() + room > BUF_BYTES || exp_desc.size() >= 31) drain_all();
      if ($urandom_range(0, 3) == 0) send_beat(8'($urandom), 1'b0, $urandom_range(0, 1), 1'b0);
      send_frame(len, err, abort_at, $urandom_range(0, 255));
      chk("rnd_drop_cnt", drop_cnt, model_drop);
      chk("rnd_empty", ptr_fifo_empty, exp_desc.size() == 0);
      if (exp_desc.size() > 0 && $urandom_range(0, 2) == 0) begin
        read_desc(v);
        len = exp_desc.pop_front();
        chk("rnd_desc", v, len);
        read_bytes(len);
      end
    end
    drain_all();

    // Reset mid-frame with two committed frames
    send_frame(20, 0, 0, 8'h21);
    send_frame(30, 0, 0, 8'h42);
    send_frame(1515, 0, 0, 8'h05);
    read_desc(v);
    read_bytes(2);
    for (int i = 0; i < 5; i++) send_beat(8'(8'h90 + i), i == 0, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_data_dout", data_fifo_dout, 0);
    chk("mid_rst_ptr_dout", ptr_fifo_dout, 0);
    chk("mid_rst_empty", ptr_fifo_empty, 1);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    exp_desc.delete();
    exp_bytes.delete();
    model_drop = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    send_frame(1, 0, 0, 8'hA5);
    chk("post_rst_empty", ptr_fifo_empty, 0);
    read_desc(v);
    chk("post_rst_desc", v, 16'h0001);
    void'(exp_desc.pop_front());
    read_bytes(1);
    chk("post_rst_drop_cnt", drop_cnt, model_drop);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
